vball_sound_latch: RTL and testbench

VBALL_SOUND_LATCH -- requirements
Module: vball_sound_latch

---
 rtl/vball_sound_latch_if.sv | 23 ++
 rtl/vball_sound_latch.sv | 110 +++++++++++
 tb/tb_vball_sound_latch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/vball_sound_latch_if.sv
// vball_sound_latch_if: main-CPU and sound-CPU bus signals for the sound command latch
interface vball_sound_latch_if;
    logic        main_ce;
    logic [15:0] main_addr;
    logic [7:0]  main_din;
    logic        main_we;
    logic [7:0]  main_rdata;
    logic        snd_ce;
    logic [15:0] snd_addr;
    logic        snd_rd;
    logic [7:0]  snd_rdata;
    logic        snd_nmi;

    modport master (
        output main_ce, main_addr, main_din, main_we, snd_ce, snd_addr, snd_rd,
        input  main_rdata, snd_rdata, snd_nmi
    );

    modport slave (
        input  main_ce, main_addr, main_din, main_we, snd_ce, snd_addr, snd_rd,
        output main_rdata, snd_rdata, snd_nmi
    );
endinterface

// File: rtl/vball_sound_latch.sv
// vball_sound_latch: main-to-sound command FIFO with status register and paced sound NMI
module vball_sound_latch #(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input logic              clk_sys,
    input logic              reset_n,
    vball_sound_latch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q, cnt_d;
    logic        ovr_q, ovr_d;
    logic        cmd_h_q, clr_h_q, rd_h_q;
    logic        main_prim_q, snd_prim_q;
    logic [7:0]  gap_q, gap_d;
    logic        cmd_lvl, clr_lvl, rd_lvl, clr_hit;
    logic        push, clr, pop, do_push, do_pop, full, empty;
    logic [3:0]  cnt4;

    assign clr_hit = bus.main_addr == 16'h100F;
    assign cmd_lvl = bus.main_we & (bus.main_addr == 16'h100D);
    assign clr_lvl = bus.main_we & clr_hit;
    assign rd_lvl  = bus.snd_rd & (bus.snd_addr[15:11] == 5'b10100);

    // Accesses only count after the first ce following reset has loaded the history,
    // so a strobe held across reset release is not mistaken for a new access.
    assign push = bus.main_ce & main_prim_q & cmd_lvl & ~cmd_h_q;
    assign clr  = bus.main_ce & main_prim_q & clr_lvl & ~clr_h_q;
    assign pop  = bus.snd_ce & snd_prim_q & rd_lvl & ~rd_h_q;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign ovr_d   = clr ? 1'b0 : (push & ~do_push) ? 1'b1 : ovr_q;
    assign cnt4    = 4'(cnt_q);

    assign bus.snd_rdata  = (rd_lvl & ~empty) ? mem_q[rp_q] : 8'h00;
    assign bus.main_rdata = (clr_hit & ~bus.main_we) ? {ovr_q, 2'b00, full, cnt4} : 8'h00;
    assign bus.snd_nmi    = state_q == S_ASSERT;

    // FIFO storage; contents need no reset because the count gates every read
    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wp_q] <= bus.main_din;
    end

    // Pointers, count, overrun flag and access-edge history
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            cmd_h_q     <= 1'b0;
            clr_h_q     <= 1'b0;
            rd_h_q      <= 1'b0;
            main_prim_q <= 1'b0;
            snd_prim_q  <= 1'b0;
        end else begin
            wp_q  <= wp_q + AW'(do_push);
            rp_q  <= rp_q + AW'(do_pop);
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
            if (bus.main_ce) begin
                main_prim_q <= 1'b1;
                cmd_h_q     <= cmd_lvl;
                clr_h_q     <= clr_lvl;
            end
            if (bus.snd_ce) begin
                snd_prim_q <= 1'b1;
                rd_h_q     <= rd_lvl;
            end
        end
    end

    // NMI state register and gap counter
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gap_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // NMI sequencing: raise while a byte waits, drop on pop, hold off GAP sound ce cycles.
    // A byte being popped this cycle does not re-raise, so an empty FIFO never sits in ASSERT.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        unique case (state_q)
            S_IDLE:   if (!empty && !pop) state_d = S_ASSERT;
            S_ASSERT: if (pop) begin
                state_d = S_GAP;
                gap_d   = 8'(GAP);
            end
            S_GAP:    if (gap_q == 8'h00) state_d = (!empty && !pop) ? S_ASSERT : S_IDLE;
                      else if (bus.snd_ce) gap_d = gap_q - 8'h01;
            default:  state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_vball_sound_latch.sv
// tb_vball_sound_latch: directed scenarios plus random traffic against a queue-based model
module tb_vball_sound_latch;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   tot_n = 0;
    int   pass_n = 0;
    bit   run_chk = 1'b0;

    vball_sound_latch_if bus ();

    vball_sound_latch #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    // Reference model: a byte queue, sticky overrun, access-edge tracking and NMI pacing
    logic [7:0] q[$];
    bit ovr, mnmi, mprim, sprim, cmd_h, clr_h, rd_h;
    int gap_left;

    function automatic bit snd_sel();
        return bus.snd_rd && bus.snd_addr >= 16'hA000 && bus.snd_addr <= 16'hA7FF;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        bit cmd_l, clr_l, rd_l, psh, clr, pp;
        int n;
        if (!reset_n) begin
            q.delete();
            ovr = 0; mnmi = 0; gap_left = -1;
            mprim = 0; sprim = 0; cmd_h = 0; clr_h = 0; rd_h = 0;
        end else begin
            cmd_l = bus.main_we && bus.main_addr == 16'h100D;
            clr_l = bus.main_we && bus.main_addr == 16'h100F;
            rd_l  = snd_sel();
            psh = bus.main_ce && mprim && cmd_l && !cmd_h;
            clr = bus.main_ce && mprim && clr_l && !clr_h;
            pp  = bus.snd_ce && sprim && rd_l && !rd_h;
            if (bus.main_ce) begin mprim = 1; cmd_h = cmd_l; clr_h = clr_l; end
            if (bus.snd_ce) begin sprim = 1; rd_h = rd_l; end
            n = q.size();
            if (mnmi) begin
                if (pp) begin mnmi = 0; gap_left = GAP; end
            end else if (gap_left >= 0) begin
                if (gap_left == 0) begin mnmi = n > 0 && !pp; gap_left = -1; end
                else if (bus.snd_ce) gap_left--;
            end else mnmi = n > 0 && !pp;
            if (pp && n > 0) void'(q.pop_front());
            if (psh) begin
                if (q.size() < DEPTH) q.push_back(bus.main_din);
                else ovr = 1;
            end
            if (clr) ovr = 0;
        end
    end

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tot_n++;
        if (got === exp) pass_n++;
        else $display("FAIL %s: got %02h expected %02h at %0t", nm, got, exp, $time);
    endtask

    // Every cycle: outputs must match what the model implies
    always @(negedge clk_sys) begin
        logic [7:0] me, se;
        if (run_chk) begin
            me = (bus.main_addr == 16'h100F && !bus.main_we) ?
                 {ovr, 2'b00, q.size() == DEPTH, 4'(q.size())} : 8'h00;
            se = (snd_sel() && q.size() > 0) ? q[0] : 8'h00;
            chk("main_rdata", bus.main_rdata, me);
            chk("snd_rdata", bus.snd_rdata, se);
            chk("snd_nmi", {7'b0, bus.snd_nmi}, {7'b0, mnmi});
        end
    end

    task automatic cyc();
        @(posedge clk_sys); #1;
    endtask

    task automatic idle();
        bus.main_addr = 16'h0000; bus.main_we = 0; bus.main_din = 8'h00;
        bus.snd_addr = 16'h0000; bus.snd_rd = 0;
    endtask

    task automatic mwrite(input logic [15:0] a, input logic [7:0] d);
        bus.main_addr = a; bus.main_din = d; bus.main_we = 1;
        cyc(); cyc();
        bus.main_we = 0; bus.main_addr = 16'h0000;
        cyc();
    endtask

    task automatic status(input string nm, input logic [7:0] exp);
        bus.main_addr = 16'h100F; bus.main_we = 0;
        @(negedge clk_sys);
        chk(nm, bus.main_rdata, exp);
        cyc();
        bus.main_addr = 16'h0000;
    endtask

    task automatic sread(input string nm, input logic [7:0] exp);
        bus.snd_addr = 16'hA000; bus.snd_rd = 1;
        @(negedge clk_sys);
        chk(nm, bus.snd_rdata, exp);
        cyc(); cyc();
        bus.snd_rd = 0; bus.snd_addr = 16'h0000;
        cyc();
    endtask

    task automatic do_reset();
        reset_n = 0;
        cyc(); cyc();
        reset_n = 1;
        cyc(); cyc();
    endtask

    initial begin
        idle();
        bus.main_ce = 1; bus.snd_ce = 1;
        cyc();
        run_chk = 1;
        do_reset();
        status("reset_status", 8'h00);

        // Single command: NMI rises one cycle after the push, falls on read
        bus.main_addr = 16'h100D; bus.main_din = 8'h5A; bus.main_we = 1;
        cyc();
        @(negedge clk_sys); chk("nmi_before", {7'b0, bus.snd_nmi}, 8'h00);
        cyc();
        @(negedge clk_sys); chk("nmi_after", {7'b0, bus.snd_nmi}, 8'h01);
        cyc();
        bus.main_we = 0; bus.main_addr = 16'h0000;
        cyc();
        sread("rd_5a", 8'h5A);
        @(negedge clk_sys); chk("nmi_idle", {7'b0, bus.snd_nmi}, 8'h00);
        repeat (4) cyc();
        status("empty_after_5a", 8'h00);

        // Three commands queued then drained in order
        mwrite(16'h100D, 8'h01); mwrite(16'h100D, 8'h02); mwrite(16'h100D, 8'h03);
        status("status_3", 8'h03);
        sread("rd_01", 8'h01); sread("rd_02", 8'h02); sread("rd_03", 8'h03);
        repeat (4) cyc();

        // Overflow: fifth byte dropped, overrun sticky until cleared
        for (int i = 1; i <= 5; i++) mwrite(16'h100D, 8'(8'h10 + i));
        status("status_ovr", 8'h94);
        for (int i = 1; i <= 4; i++) sread("rd_ovr", 8'(8'h10 + i));
        mwrite(16'h100F, 8'hFF);
        status("status_clr", 8'h00);
        repeat (4) cyc();

        // Held strobes: one push and one pop each, with ce toggling
        bus.main_addr = 16'h100D; bus.main_din = 8'h77; bus.main_we = 1;
        for (int i = 0; i < 20; i++) begin bus.main_ce = i[0]; cyc(); end
        bus.main_ce = 1; bus.main_we = 0; bus.main_addr = 16'h0000;
        cyc();
        status("held_push", 8'h01);
        bus.snd_addr = 16'hA123; bus.snd_rd = 1;
        for (int i = 0; i < 20; i++) begin bus.snd_ce = i[0]; cyc(); end
        bus.snd_ce = 1; bus.snd_rd = 0; bus.snd_addr = 16'h0000;
        cyc();
        status("held_pop", 8'h00);
        repeat (4) cyc();

        // Full FIFO with push and pop on the same edge
        for (int i = 1; i <= 4; i++) mwrite(16'h100D, 8'(8'hA0 + i));
        bus.main_addr = 16'h100D; bus.main_din = 8'hB5; bus.main_we = 1;
        bus.snd_addr = 16'hA000; bus.snd_rd = 1;
        cyc();
        idle();
        cyc();
        status("full_swap", 8'h14);
        sread("rd_a2", 8'hA2); sread("rd_a3", 8'hA3); sread("rd_a4", 8'hA4); sread("rd_b5", 8'hB5);
        repeat (4) cyc();

        // Reset with queued bytes discards them
        mwrite(16'h100D, 8'h31); mwrite(16'h100D, 8'h32); mwrite(16'h100D, 8'h33);
        reset_n = 0;
        #1 chk("rst_nmi", {7'b0, bus.snd_nmi}, 8'h00);
        bus.main_addr = 16'h100F; bus.snd_addr = 16'hA000; bus.snd_rd = 1;
        @(negedge clk_sys);
        chk("rst_status", bus.main_rdata, 8'h00);
        chk("rst_read", bus.snd_rdata, 8'h00);
        cyc();
        idle();
        reset_n = 1;
        cyc(); cyc();

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            bus.main_ce = $urandom_range(0, 2) != 0;
            bus.snd_ce  = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 4))
                    0, 1, 2: bus.main_addr = 16'h100D;
                    3: bus.main_addr = 16'h100F;
                    default: bus.main_addr = 16'($urandom);
                endcase
                bus.main_we  = $urandom_range(0, 1);
                bus.main_din = 8'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.snd_addr = ($urandom_range(0, 3) != 0) ? 16'hA000 + 16'($urandom_range(0, 16'h7FF)) : 16'($urandom);
                bus.snd_rd   = $urandom_range(0, 2) == 0;
            end
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 0; cyc(); reset_n = 1;
            end
            cyc();
        end

        run_chk = 0;
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
